// File: rtl/btn_event_counter.sv
// Button event generator and modulo up/down step counter fed by a debounced level.
// Build option: define AUTO_REPEAT_EN to add the auto-repeat state after a long press.
module btn_event_counter #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned MOD_MAX       = 99,
   parameter int unsigned LONG_CYCLES   = 50000000,
   parameter int unsigned REPEAT_CYCLES = 10000000,
   parameter int unsigned TW            = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             db_level,
   input  logic             dir,
   input  logic             clr,
   output logic             press_tick,
   output logic             release_tick,
   output logic             long_tick,
   output logic             step_tick,
   output logic             wrap_tick,
   output logic [WIDTH-1:0] count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      REPEAT  = 2'd2
   } state_e;

   localparam logic [TW-1:0]    LONG_LAST = TW'(LONG_CYCLES - 1);
   localparam logic [TW-1:0]    RPT_LAST  = TW'(REPEAT_CYCLES - 1);
   localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(MOD_MAX);

   state_e           state_q, state_d;
   logic             lvl_q;
   logic             arm_q, arm_d;
   logic             long_done_q, long_done_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             long_q, long_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;

   logic             rise_c;
   logic             step_c;
   logic [TW-1:0]    timer_last_c;

   // A level already high when reset releases must drop once before it can count as a press.
   assign rise_c       = db_level & ~lvl_q & arm_q;
   assign timer_last_c = (state_q == REPEAT) ? RPT_LAST : LONG_LAST;

   // Next-state, event and counter logic
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      long_done_d = long_done_q;
      arm_d       = arm_q | ~db_level;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      step_c      = 1'b0;
      count_d     = count_q;
      wrap_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (rise_c) begin
               press_d     = 1'b1;
               step_c      = 1'b1;
               timer_d     = '0;
               long_done_d = 1'b0;
               state_d     = PRESSED;
            end
         end
         PRESSED: begin
            if (!db_level) begin
               release_d = 1'b1;
               state_d   = IDLE;
            end else if (!long_done_q && (timer_q == timer_last_c)) begin
               long_d  = 1'b1;
               timer_d = '0;
`ifdef AUTO_REPEAT_EN
               step_c  = 1'b1;
               state_d = REPEAT;
`else
               long_done_d = 1'b1;
`endif
            end else if (!long_done_q) begin
               timer_d = timer_q + TW'(1);
            end
         end
`ifdef AUTO_REPEAT_EN
         REPEAT: begin
            if (!db_level) begin
               release_d = 1'b1;
               state_d   = IDLE;
            end else if (timer_q == timer_last_c) begin
               step_c  = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      // Clear wins over a simultaneous step; the step still reports but never wraps.
      if (clr) begin
         count_d = '0;
      end else if (step_c) begin
         if (dir) begin
            if (count_q == CNT_MAX) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == '0) begin
               count_d = CNT_MAX;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
      step_d = step_c;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         lvl_q       <= 1'b0;
         arm_q       <= 1'b0;
         long_done_q <= 1'b0;
         timer_q     <= '0;
         count_q     <= '0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         step_q      <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lvl_q       <= db_level;
         arm_q       <= arm_d;
         long_done_q <= long_done_d;
         timer_q     <= timer_d;
         count_q     <= count_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
         step_q      <= step_d;
         wrap_q      <= wrap_d;
      end
   end

   assign press_tick   = press_q;
   assign release_tick = release_q;
   assign long_tick    = long_q;
   assign step_tick    = step_q;
   assign wrap_tick    = wrap_q;
   assign count        = count_q;

endmodule

// File: tb/tb_btn_event_counter.sv
// Self-checking bench for btn_event_counter: directed table, corner sequences, random vs model.
module tb_btn_event_counter;

   localparam int unsigned W     = 4;
   localparam int unsigned MODV  = 9;
   localparam int unsigned LONGV = 10;
   localparam int unsigned REPV  = 4;
`ifdef AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         db_level = 1'b0;
   logic         dir = 1'b0;
   logic         clr = 1'b0;
   logic         press_tick, release_tick, long_tick, step_tick, wrap_tick;
   logic [W-1:0] count;

   btn_event_counter #(
      .WIDTH(W), .MOD_MAX(MODV), .LONG_CYCLES(LONGV), .REPEAT_CYCLES(REPV), .TW(26)
   ) dut (
      .clk(clk), .reset(reset), .db_level(db_level), .dir(dir), .clr(clr),
      .press_tick(press_tick), .release_tick(release_tick), .long_tick(long_tick),
      .step_tick(step_tick), .wrap_tick(wrap_tick), .count(count)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Reference model: counts cycles since the press, events fall out of plain arithmetic.
   bit m_pressed, m_armed, m_prev;
   int m_k, m_count;
   bit m_press, m_rel, m_long, m_step, m_wrap;

   task automatic model_reset();
      m_pressed = 0; m_armed = 0; m_prev = 0; m_k = 0; m_count = 0;
      m_press = 0; m_rel = 0; m_long = 0; m_step = 0; m_wrap = 0;
   endtask

   task automatic model_edge(input bit d, input bit dr, input bit c);
      bit st;
      st = 0;
      m_press = 0; m_rel = 0; m_long = 0; m_wrap = 0;
      if (!m_pressed) begin
         if (d && !m_prev && m_armed) begin
            m_press = 1; st = 1; m_pressed = 1; m_k = 0;
         end
      end else if (!d) begin
         m_rel = 1; m_pressed = 0;
      end else begin
         m_k++;
         if (m_k == LONGV) begin
            m_long = 1; st = AUTO;
         end else if (AUTO && m_k > LONGV && ((m_k - LONGV) % REPV) == 0) begin
            st = 1;
         end
      end
      m_step = st;
      if (c) m_count = 0;
      else if (st) begin
         if (dr) begin
            if (m_count == MODV) begin m_count = 0; m_wrap = 1; end
            else m_count = m_count + 1;
         end else begin
            if (m_count == 0) begin m_count = MODV; m_wrap = 1; end
            else m_count = m_count - 1;
         end
      end
      m_prev = d;
      if (!d) m_armed = 1;
   endtask

   function automatic logic [8:0] dut_vec();
      return {press_tick, release_tick, long_tick, step_tick, wrap_tick, count};
   endfunction

   function automatic logic [8:0] model_vec();
      return {m_press, m_rel, m_long, m_step, m_wrap, 4'(m_count)};
   endfunction

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got p/r/l/s/w=%b count=%0d, want p/r/l/s/w=%b count=%0d",
                    name, act[8:4], act[3:0], exp[8:4], exp[3:0]);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   task automatic drive(input logic d, input logic dr, input logic c);
      @(negedge clk);
      db_level = d; dir = dr; clr = c;
      @(posedge clk);
      model_edge(d, dr, c);
      #1;
   endtask

   task automatic cyc(input logic d, input logic dr, input logic c, input string name);
      drive(d, dr, c);
      check(name, dut_vec(), model_vec());
   endtask

   task automatic presses_up(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b1, 1'b0, "press_up");
         cyc(1'b0, 1'b1, 1'b0, "release_up");
      end
   endtask

   typedef struct {
      logic       db;
      logic       dr;
      logic       c;
      logic [8:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic d, input logic dr, input logic c,
                               input logic [4:0] ticks, input logic [3:0] cnt);
      vec_t v;
      v.db = d; v.dr = dr; v.c = c; v.exp = {ticks, cnt};
      return v;
   endfunction

   initial begin
      vec_t tbl[16];
      int   longs, steps, long_at, c0;
      logic dbr;

      // ticks field order: press, release, long, step, wrap
      tbl[0]  = mk(0, 1, 0, 5'b00000, 4'd0);
      tbl[1]  = mk(1, 1, 0, 5'b10010, 4'd1);
      tbl[2]  = mk(1, 1, 0, 5'b00000, 4'd1);
      tbl[3]  = mk(1, 1, 0, 5'b00000, 4'd1);
      tbl[4]  = mk(0, 1, 0, 5'b01000, 4'd1);
      tbl[5]  = mk(0, 1, 0, 5'b00000, 4'd1);
      tbl[6]  = mk(1, 0, 0, 5'b10010, 4'd0);
      tbl[7]  = mk(0, 0, 0, 5'b01000, 4'd0);
      tbl[8]  = mk(1, 0, 0, 5'b10011, 4'd9);
      tbl[9]  = mk(0, 0, 0, 5'b01000, 4'd9);
      tbl[10] = mk(1, 1, 0, 5'b10011, 4'd0);
      tbl[11] = mk(0, 1, 0, 5'b01000, 4'd0);
      tbl[12] = mk(1, 1, 0, 5'b10010, 4'd1);
      tbl[13] = mk(0, 1, 1, 5'b01000, 4'd0);
      tbl[14] = mk(1, 1, 1, 5'b10010, 4'd0);
      tbl[15] = mk(0, 1, 0, 5'b01000, 4'd0);

      model_reset();
      #3 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("reset_state", dut_vec(), 9'd0);
      @(negedge clk) reset = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].db, tbl[i].dr, tbl[i].c);
         check($sformatf("tbl%0d", i), dut_vec(), tbl[i].exp);
      end

      // clear colliding with a step at count 4
      cyc(1'b0, 1'b1, 1'b1, "clr_idle");
      presses_up(4);
      check_int("pre_clr_count", int'(count), 4);
      cyc(1'b1, 1'b1, 1'b1, "clr_step_model");
      check("clr_step", dut_vec(), {5'b10010, 4'd0});
      cyc(1'b0, 1'b1, 1'b0, "clr_step_rel");

      // long hold of 30 cycles
      presses_up(3);
      c0 = m_count;
      longs = 0; steps = 0; long_at = -1;
      for (int i = 0; i < 30; i++) begin
         cyc(1'b1, 1'b1, 1'b0, "hold");
         if (long_tick) begin longs++; long_at = i; end
         if (step_tick) steps++;
      end
      cyc(1'b0, 1'b1, 1'b0, "hold_release");
      check_int("hold_long_count", longs, 1);
      check_int("hold_long_at", long_at, LONGV);
      check_int("hold_steps", steps, AUTO ? 6 : 1);
      check_int("hold_final_count", int'(count), (c0 + (AUTO ? 6 : 1)) % (MODV + 1));

      // reset mid-press at count 5
      cyc(1'b0, 1'b1, 1'b1, "rst_prep_clr");
      presses_up(4);
      cyc(1'b1, 1'b1, 1'b0, "rst_press");
      check_int("rst_press_count", int'(count), 5);
      #2 reset = 1'b0;
      #1 check("reset_async", dut_vec(), 9'd0);
      model_reset();
      @(posedge clk);
      #1 check("reset_held", dut_vec(), 9'd0);
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, "post_rst_high");
      cyc(1'b0, 1'b1, 1'b0, "post_rst_low");
      cyc(1'b1, 1'b1, 1'b0, "rearm_model");
      check("rearm_press", dut_vec(), {5'b10010, 4'd1});
      cyc(1'b0, 1'b1, 1'b0, "rearm_release");

      // randomized run against the model
      dbr = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) dbr = ~dbr;
         cyc(dbr, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), "rand");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
